axis_detector_merger: RTL

- Collects event words from NUM_INPUTS detector readers, which are tvalid-only sources with no backpressure, and merges them into one AXI4-Stream master with tready.
- Each input has a one-entry holding register; a round-robin arbiter drains the holding registers into a single output register.
- A run state machine gates acquisition: enable, optional event limit, drain, done.
- Drop and event counters are exported as status.

---
 rtl/axis_detector_merger_pkg.sv | 24 ++
 rtl/axis_detector_merger_rr_arbiter.sv | 37 +++
 rtl/axis_detector_merger.sv | 120 ++++++++++++
 3 files changed

// File: rtl/axis_detector_merger_pkg.sv
// axis_detector_merger_pkg: run-state encoding and shared helpers for the detector merger.
package axis_detector_merger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int idx_width(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Adds d to v and clamps at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(logic [63:0] v, logic [63:0] d, int w);
        logic [63:0] mx;
        logic [63:0] s;
        mx = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        s = v + d;
        return (s > mx || s < v) ? mx : s;
    endfunction

endpackage

// File: rtl/axis_detector_merger_rr_arbiter.sv
// axis_rr_arbiter: round-robin grant from a request vector; pointer advances past each accepted grant.
module axis_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr;
    int j;

    // Descending scan so the request closest to the pointer is the last one written.
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                gnt = IW'(j);
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ptr <= '0;
        else if (accept && gnt_vld) ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
    end

endmodule

// File: rtl/axis_detector_merger.sv
// axis_detector_merger: merges tvalid-only detector readers into one AXI4-Stream master
// through per-input holding registers, a round-robin arbiter and a run/drain state machine.
module axis_detector_merger
    import axis_detector_merger_pkg::*;
#(
    parameter int NUM_INPUTS       = 4,
    parameter int AXIS_TDATA_WIDTH = 128,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 cfg_enable,
    input  logic [CNTR_WIDTH-1:0]                cfg_limit,
    input  logic [NUM_INPUTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]                s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
    output logic [2:0]                           m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [CNTR_WIDTH-1:0]                sts_events,
    output logic [CNTR_WIDTH-1:0]                sts_drops,
    output logic [1:0]                           sts_state
);

    localparam int IW = idx_width(NUM_INPUTS);
    localparam int W  = AXIS_TDATA_WIDTH;

    state_t st, st_nx;
    logic [NUM_INPUTS-1:0] hold_vld, cap;
    logic [W-1:0] hold_data [NUM_INPUTS];
    logic [IW-1:0] gnt;
    logic gnt_vld, load, active, take, limited;
    logic [63:0] n_acc, n_drop;

    assign load    = !m_axis_tvalid || m_axis_tready;
    assign active  = (st == ST_RUN) || (st == ST_DRAIN);
    assign take    = gnt_vld && load && active;
    assign limited = (cfg_limit != '0) && (sts_events >= cfg_limit);
    assign sts_state = st;

    axis_rr_arbiter #(.N(NUM_INPUTS), .IW(IW)) u_arb (
        .aclk    (aclk),
        .areset  (areset),
        .req     (hold_vld),
        .accept  (load && active),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // Ascending scan gives lower indices priority when the limit cuts a burst short.
    always_comb begin
        cap = '0;
        n_acc = '0;
        n_drop = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (st == ST_RUN && s_axis_tvalid[i]) begin
                if ((!hold_vld[i] || (take && gnt == IW'(i))) &&
                    (cfg_limit == '0 || 64'(sts_events) + n_acc < 64'(cfg_limit))) begin
                    cap[i] = 1'b1;
                    n_acc = n_acc + 64'd1;
                end else begin
                    n_drop = n_drop + 64'd1;
                end
            end
        end
    end

    always_comb begin
        st_nx = st;
        if (st == ST_IDLE && cfg_enable) st_nx = ST_RUN;
        if (st == ST_RUN && (!cfg_enable || limited)) st_nx = ST_DRAIN;
        if (st == ST_DRAIN && hold_vld == '0 && !m_axis_tvalid) st_nx = ST_DONE;
        if (st == ST_DONE && !cfg_enable) st_nx = ST_IDLE;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) st <= ST_IDLE;
        else st <= st_nx;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_events <= '0;
            sts_drops <= '0;
        end else if (st == ST_IDLE && cfg_enable) begin
            sts_events <= '0;
            sts_drops <= '0;
        end else begin
            sts_events <= CNTR_WIDTH'(sat_inc(64'(sts_events), n_acc, CNTR_WIDTH));
            sts_drops <= CNTR_WIDTH'(sat_inc(64'(sts_drops), n_drop, CNTR_WIDTH));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_vld <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) hold_data[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (cap[i]) hold_data[i] <= s_axis_tdata[i*W +: W];
                hold_vld[i] <= cap[i] || (hold_vld[i] && !(take && gnt == IW'(i)));
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata <= '0;
            m_axis_tuser <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (take) begin
            m_axis_tdata <= hold_data[gnt];
            m_axis_tuser <= 3'(gnt);
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
